mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   Consumer end of the EX/MEM pipeline register: the MEM stage of the 5-stage MIPS pipeline.
//   Holds the word-addressed data memory, resolves branches (PCSrc), and registers MEM/WB outputs.
//   Memory has a configurable multi-cycle latency. oStall freezes IF/ID/EX and EX/MEM while an access completes.
// PARAMETERS
//   ADDR_WIDTH   8   word-address bits; memory depth = 2**ADDR_WIDTH x 32-bit words
//   MEM_LATENCY  2   cycles per load/store access (>=1); 1 = single-cycle, never stalls
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   asynchronous, active-high reset
//   iRegWrite       in   1   EX/MEM: write-back enable
//   iMemToReg       in   1   EX/MEM: 1 = write back load data, 0 = ALU result
//   iMemWrite       in   1   EX/MEM: store request
//   iMemRead        in   1   EX/MEM: load request
//   iMemBranch      in   1   EX/MEM: branch instruction
//   iBranchResult   in   32  EX/MEM: branch target address
//   iZFlag          in   1   EX/MEM: ALU zero flag
//   iAluRes         in   32  EX/MEM: ALU result / memory byte address
//   iData2          in   32  EX/MEM: store data
//   iRegDestMux     in   5   EX/MEM: destination register
//   oPCSrc          out  1   iMemBranch & iZFlag (combinational)
//   oBranchTarget   out  32  iBranchResult (combinational pass-through)
//   oStall          out  1   hold upstream stages and EX/MEM this cycle
//   oRegWrite       out  1   MEM/WB: write-back enable
//   oMemToReg       out  1   MEM/WB: write-back select
//   oReadData       out  32  MEM/WB: load data
//   oAluRes         out  32  MEM/WB: ALU result
//   oRegDestMux     out  5   MEM/WB: destination register
//   oWriteData      out  32  oMemToReg ? oReadData : oAluRes (combinational from MEM/WB regs)
// BEHAVIOUR
//   Address: word index = iAluRes[ADDR_WIDTH+1:2]. Bits [1:0] and the bits above are ignored, so addresses wrap.
//   FSM has two states, IDLE and BUSY. A counter cnt counts remaining stall cycles.
//     IDLE, access=(iMemRead|iMemWrite), MEM_LATENCY>1:
//       oStall=1. Next state BUSY, cnt<=MEM_LATENCY-2.
//     IDLE, otherwise:
//       oStall=0. The access (if any) completes this edge.
//     BUSY, cnt!=0: oStall=1, cnt<=cnt-1.
//     BUSY, cnt==0: oStall=0. The access completes this edge. Next state IDLE.
//   Inputs are held stable by upstream whenever oStall=1. The block does not re-sample them.
//   Completion edge (oStall=0):
//     - MEM/WB loads all inputs; oReadData <= mem[idx].
//     - Store: mem[idx] <= iData2, written exactly once.
//     - Read-before-write: a load+store pair returns the old word.
//   Stall edge (oStall=1): MEM/WB loads a bubble.
//     - oRegWrite=0 and oMemToReg=0; other MEM/WB fields hold.
//     - The memory is not written.
//   Non-memory instructions never stall. MEM/WB captures them every edge with 1-cycle latency.
//   A load takes MEM_LATENCY cycles from EX/MEM presentation to MEM/WB valid.
//   oPCSrc/oBranchTarget are purely combinational and ignore stall state. Branches carry no memory op.
//   Reset (async, any time, including mid-access):
//     - state=IDLE, cnt=0.
//     - oRegWrite, oMemToReg, oReadData, oAluRes and oRegDestMux all 0.
//     - A pending store is discarded. Memory contents are NOT cleared.
//   Counter width: $clog2(MEM_LATENCY)+1. MEM_LATENCY=1 synthesises no BUSY path.
// TESTING
//   1) Reset: assert rst mid-BUSY during a store.
//      -> All MEM/WB outputs 0 and oStall=0 immediately. Target word unchanged.
//   2) ALU op (iRegWrite=1, iMemToReg=0, iAluRes=32'h1234, iRegDestMux=5'd9).
//      -> Next edge: oWriteData=32'h1234, oRegDestMux=9, no stall.
//   3) MEM_LATENCY=3: store 32'hDEADBEEF @ 0x10, then load @ 0x10.
//      -> oStall high 2 cycles per access; 2 bubbles per access (oRegWrite=0).
//      -> Load result oReadData=32'hDEADBEEF, MEM/WB valid 3 cycles after presentation.
//   4) ADDR_WIDTH=8: store 32'hA5 @ 0x400, then load @ 0x000.
//      -> Reads 32'hA5 (wrap). Load @ 0x403 also reads 32'hA5.
//   5) iMemBranch=1, iZFlag=1, iBranchResult=32'h80.
//      -> oPCSrc=1 and oBranchTarget=32'h80 in the same cycle.
//      -> With iZFlag=0: oPCSrc=0.
//   6) Load and store same cycle @ 0x20 (old 32'h1, new 32'h2).
//      -> oReadData=32'h1. A later load returns 32'h2.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data memory with multi-cycle
// access latency, branch resolution, and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iRegWrite,
    input  logic        iMemToReg,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    input  logic        iMemBranch,
    input  logic [31:0] iBranchResult,
    input  logic        iZFlag,
    input  logic [31:0] iAluRes,
    input  logic [31:0] iData2,
    input  logic [4:0]  iRegDestMux,
    output logic        oPCSrc,
    output logic [31:0] oBranchTarget,
    output logic        oStall,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [31:0] oReadData,
    output logic [31:0] oAluRes,
    output logic [4:0]  oRegDestMux,
    output logic [31:0] oWriteData
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = $clog2(MEM_LATENCY) + 1;
    localparam int unsigned LAT_M2 = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
    localparam bit          MULTI  = (MEM_LATENCY > 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_next_cnt;
    logic                    w_stall;
    logic                    w_access;
    logic                    w_complete;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic                    w_unused_addr_bits;

    logic [31:0]             r_mem [DEPTH];
    logic                    r_reg_write;
    logic                    r_mem_to_reg;
    logic [31:0]             r_read_data;
    logic [31:0]             r_alu_res;
    logic [4:0]              r_reg_dest;

    // Byte address to word index; upper bits are dropped so addresses wrap.
    assign w_idx              = iAluRes[ADDR_WIDTH+1:2];
    assign w_unused_addr_bits = ^{iAluRes[31:ADDR_WIDTH+2], iAluRes[1:0]};
    assign w_access           = iMemRead | iMemWrite;
    // Reset forces the stage idle, so no stall and no memory write while it is held.
    assign w_complete         = ~w_stall & ~rst;

    assign oPCSrc        = iMemBranch & iZFlag;
    assign oBranchTarget = iBranchResult;
    assign oStall        = w_stall & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (MULTI && w_access) begin
                    w_stall      = 1'b1;
                    w_next_state = BUSY;
                    w_next_cnt   = CNT_W'(LAT_M2);
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_stall    = 1'b1;
                    w_next_cnt = r_cnt - CNT_W'(1);
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Memory contents survive reset; a store commits only on its completion edge.
    always_ff @(posedge clk) begin
        if (w_complete && iMemWrite) begin
            r_mem[w_idx] <= iData2;
        end
    end

    // MEM/WB register: a bubble (no write-back) on stall edges, full capture otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_read_data  <= '0;
            r_alu_res    <= '0;
            r_reg_dest   <= '0;
        end else if (w_stall) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_reg_write  <= iRegWrite;
            r_mem_to_reg <= iMemToReg;
            r_read_data  <= r_mem[w_idx];
            r_alu_res    <= iAluRes;
            r_reg_dest   <= iRegDestMux;
        end
    end

    assign oRegWrite   = r_reg_write;
    assign oMemToReg   = r_mem_to_reg;
    assign oReadData   = r_read_data;
    assign oAluRes     = r_alu_res;
    assign oRegDestMux = r_reg_dest;
    assign oWriteData  = r_mem_to_reg ? r_read_data : r_alu_res;

endmodule
